instr_fetch_unit: RTL and testbench

Instruction fetch front end of the rv32i core: the reading initiator for the byte-addressed, little-endian instruction memory, whose read data is combinational. It drives the fetch address, captures each returned 32-bit word with its PC into a small prefetch FIFO, and presents them to decode over a valid/ready handshake. Execute redirects it on branches and jumps; a misaligned redirect target halts fetch with a fault.

---
 rtl/instr_fetch_unit.sv | 76 +++++++
 tb/tb_instr_fetch_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: rv32i fetch front end driving imem_addr from F_PC, buffering {pc, instr} in a prefetch FIFO for decode (fetch_valid/ready/instr/pc), redirected by execute (redirect_valid/pc), halting with sticky fault/fault_pc on a misaligned target; clk, async active-high rst
module instr_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_instruction,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  fetch_valid,
  input  logic                  fetch_ready,
  output logic [DATA_WIDTH-1:0] fetch_instr,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] fault_pc
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  typedef enum logic {RUN, HALT} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] f_pc;
  logic [ADDR_WIDTH-1:0] pc_m [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] in_m [FIFO_DEPTH];
  logic [PW-1:0] rd, wr;
  logic [CW-1:0] count;
  logic pop, push, redir;
  assign imem_addr = f_pc;
  assign fetch_valid = count != '0;
  assign fetch_instr = in_m[rd];
  assign fetch_pc = pc_m[rd];
  always_comb begin
    pop = fetch_valid & fetch_ready;
    redir = (state == RUN) & redirect_valid;
    push = (state == RUN) & ~redirect_valid & ((count < FULL) | pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      f_pc <= RESET_PC;
      rd <= '0;
      wr <= '0;
      count <= '0;
      fault <= 1'b0;
      fault_pc <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_m[i] <= '0;
        in_m[i] <= '0;
      end
    end else if (redir) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      if (redirect_pc[1:0] != 2'b00) begin
        state <= HALT;
        fault <= 1'b1;
        fault_pc <= redirect_pc;
      end else begin
        f_pc <= redirect_pc;
      end
    end else begin
      if (push) begin
        pc_m[wr] <= f_pc;
        in_m[wr] <= imem_instruction;
        wr <= wr + PW'(1);
        f_pc <= f_pc + ADDR_WIDTH'(4);
      end
      if (pop) rd <= rd + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized scoreboard bench for instr_fetch_unit against a stream-level reference model
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h0: return 32'h00000093;
      32'h4: return 32'h00100113;
      32'h8: return 32'h00A00193;
      32'hC: return 32'h002080B3;
      default: return {a[15:0], ~a[15:0]} ^ 32'h13579BDF;
    endcase
  endfunction
  logic [31:0] imem_addr, imem_instruction, redirect_pc, fetch_instr, fetch_pc, fault_pc;
  logic redirect_valid = 1'b0, fetch_ready = 1'b0, fetch_valid, fault;
  logic [31:0] w_addr, w_instr_in, w_rpc = '0, w_instr, w_pc, w_fault_pc;
  logic w_rv = 1'b0, w_ready = 1'b1, w_valid, w_fault;
  assign imem_instruction = mem_f(imem_addr);
  assign w_instr_in = mem_f(w_addr);
  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instruction(imem_instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fault(fault), .fault_pc(fault_pc)
  );
  instr_fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut_w (
    .clk(clk), .rst(rst), .imem_addr(w_addr), .imem_instruction(w_instr_in),
    .redirect_valid(w_rv), .redirect_pc(w_rpc), .fetch_valid(w_valid),
    .fetch_ready(w_ready), .fetch_instr(w_instr), .fetch_pc(w_pc),
    .fault(w_fault), .fault_pc(w_fault_pc)
  );
  int checks = 0, errors = 0;
  logic [63:0] q[$];
  logic [63:0] mon_e;
  logic [31:0] exp_next, fpc_exp, rpc;
  bit halt, fault_exp, r, rv;
  int since;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    chk("valid", {31'b0, fetch_valid}, {31'b0, !halt && since > 0});
    chk("fault", {31'b0, fault}, {31'b0, fault_exp});
    if (fault_exp) chk("fault_pc", fault_pc, fpc_exp);
    if (fetch_valid && fetch_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_empty: got pc %h expected no delivery", fetch_pc);
      end else begin
        mon_e = q.pop_front();
        chk("pc", fetch_pc, mon_e[63:32]);
        chk("instr", fetch_instr, mon_e[31:0]);
      end
    end
  end
  task automatic refill();
    while (q.size() < 4) begin
      q.push_back({exp_next, mem_f(exp_next)});
      exp_next += 32'd4;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    fetch_ready = 1'b0;
    redirect_valid = 1'b0;
    q.delete();
    halt = 0;
    fault_exp = 0;
    since = 0;
    exp_next = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, fetch_valid}, 32'h0);
    chk("rst_instr", fetch_instr, 32'h0);
    chk("rst_pc", fetch_pc, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    chk("rst_w_addr", w_addr, 32'hFFFFFFFC);
    refill();
    rst = 1'b0;
  endtask
  task automatic step(input bit sr, input bit srv, input logic [31:0] srpc);
    fetch_ready = sr;
    redirect_valid = srv;
    redirect_pc = srpc;
    @(posedge clk);
    #1;
    if (srv && !halt) begin
      q.delete();
      since = 0;
      if (srpc[1:0] != 2'b00) begin
        halt = 1;
        fault_exp = 1;
        fpc_exp = srpc;
      end else begin
        exp_next = srpc;
      end
    end else if (!halt) begin
      since++;
    end
    refill();
  endtask
  initial begin
    do_reset();
    step(1, 0, 0);
    chk("wrap_valid", {31'b0, w_valid}, 32'h1);
    chk("wrap_pc0", w_pc, 32'hFFFFFFFC);
    chk("wrap_instr0", w_instr, mem_f(32'hFFFFFFFC));
    step(1, 0, 0);
    chk("wrap_pc1", w_pc, 32'h0);
    chk("wrap_instr1", w_instr, mem_f(32'h0));
    chk("wrap_fault", {31'b0, w_fault}, 32'h0);
    repeat (3) step(1, 0, 0);
    step(1, 1, 32'hC);
    chk("redir_bubble", {31'b0, fetch_valid}, 32'h0);
    repeat (4) step(1, 0, 0);
    do_reset();
    repeat (5) step(0, 0, 0);
    chk("bp_addr", imem_addr, 32'h8);
    chk("bp_pc", fetch_pc, 32'h0);
    repeat (4) step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, fetch_valid}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    do_reset();
    repeat (3) step(1, 0, 0);
    step(1, 1, 32'hE);
    chk("mis_fault", {31'b0, fault}, 32'h1);
    chk("mis_fault_pc", fault_pc, 32'hE);
    repeat (3) step(1, 0, 0);
    step(1, 1, 32'h0);
    repeat (3) step(1, 0, 0);
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (halt && $urandom_range(0, 7) == 0) do_reset();
      else begin
        r = $urandom_range(0, 3) != 0;
        rv = $urandom_range(0, 11) == 0;
        rpc = $urandom_range(0, 63) << 2;
        if ($urandom_range(0, 9) == 0) rpc[0] = 1'b1;
        step(r, rv, rpc);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
